// File: rtl/seg7_scan_driver_pkg.sv
// Segment patterns and bit positions for the seven-segment scan driver.
// Segment vectors are ordered {g,f,e,d,c,b,a}, 1 = lit.
package seg7_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  // A dash is the middle bar only.
  localparam logic [6:0] SEG_DASH  = 7'(1 << SEG_G);
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the timer logic (master) and the scan driver (slave).
interface seg7_scan_driver_if #(
  parameter int N_DIGITS = 4
);
  logic [4*N_DIGITS-1:0] digits_bcd;
  logic                  load;
  logic                  blank_lead;
  logic                  blink_en;
  logic [6:0]            seg;
  logic [N_DIGITS-1:0]   an;

  modport master (
    output digits_bcd, load, blank_lead, blink_en,
    input  seg, an
  );

  modport slave (
    input  digits_bcd, load, blank_lead, blink_en,
    output seg, an
  );
endinterface

// File: rtl/seg7_scan_driver_bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder; codes 10-15 show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [6:0] o_seg
);

  // Table lookup for valid BCD, dash for anything above 9.
  always_comb begin
    o_seg = SEG_DASH;
    if (i_code <= 4'd9) o_seg = SEG_DIGIT[i_code];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: shadow register, digit scan,
// leading-zero blanking and registered segment/anode outputs.
// Optional blink mode is built only when SEG7_BLINK_EN is defined.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_an;

  logic                  w_term;
  logic                  w_wrap;
  logic [3:0]            w_code;
  logic [6:0]            w_pat;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_all0;
  logic                  w_blank;
  logic [N_DIGITS-1:0]   w_an;
  logic                  w_show;

  assign w_term = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_wrap = (r_idx == IDX_W'(N_DIGITS - 1));

  // Dwell counter and digit index; index steps once per dwell.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_term) begin
      r_cnt <= '0;
      r_idx <= w_wrap ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Shadow register: whole word replaced at once so no torn display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_shadow <= '0;
    else if (bus.load) r_shadow <= bus.digits_bcd;
  end

  assign w_code = r_shadow[4*r_idx +: 4];

  bcd_to_seg7 u_dec (
    .i_code (w_code),
    .o_seg  (w_pat)
  );

  // w_lz[i]: digit i and every more significant digit are zero
  // (invalid codes are nonzero, so they stop the blanking run).
  always_comb begin
    w_all0 = 1'b1;
    w_lz   = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      w_all0 = w_all0 & (r_shadow[4*i +: 4] == 4'd0);
      w_lz[i] = w_all0;
    end
  end

  assign w_blank = bus.blank_lead && w_lz[r_idx] && (r_idx != '0);

  // One-hot anode for the current index.
  always_comb begin
    w_an = '0;
    w_an[r_idx] = 1'b1;
  end

`ifdef SEG7_BLINK_EN
  localparam int ROT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [ROT_W-1:0] r_rot;
  logic             r_phase_on;

  // Rotation counter toggles the blink phase every BLINK_DIV wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rot      <= '0;
      r_phase_on <= 1'b1;
    end else if (w_term && w_wrap) begin
      if (r_rot == ROT_W'(BLINK_DIV - 1)) begin
        r_rot      <= '0;
        r_phase_on <= ~r_phase_on;
      end else begin
        r_rot <= r_rot + 1'b1;
      end
    end
  end

  assign w_show = ~(bus.blink_en & ~r_phase_on);
`else
  logic w_unused_blink;
  assign w_unused_blink = bus.blink_en;
  assign w_show = 1'b1;
`endif

  // Registered outputs: anode and pattern for the current digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an  <= '0;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_show ? w_an : '0;
      r_seg <= (!w_show || w_blank) ? SEG_BLANK : w_pat;
    end
  end

  assign bus.seg = r_seg;
  assign bus.an  = r_an;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver (N_DIGITS=4, SCAN_DIV=4),
// plus a second instance with SCAN_DIV=1.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.N_DIGITS(4)) bus1 ();

  seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  seg7_scan_driver #(.N_DIGITS(4), .SCAN_DIV(1), .BLINK_DIV(2)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // Reset, then release on a falling edge with optional load pending for
  // the first rising edge. Caller's next negedge is cycle n=1.
  task automatic do_reset(input logic [15:0] val, input logic ld);
    @(negedge clk);
    rst_n = 1'b0;
    bus0.load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus0.digits_bcd = val;
    bus0.load = ld;
  endtask

  task automatic test_reset;
    bus0.digits_bcd = '0; bus0.load = 0; bus0.blank_lead = 0; bus0.blink_en = 0;
    bus1.digits_bcd = '0; bus1.load = 0; bus1.blank_lead = 0; bus1.blink_en = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus0.an !== 4'b0000) begin
      errors++; $display("FAIL reset_an got=%b exp=0000", bus0.an);
    end
    checks++;
    if (bus0.seg !== 7'h00) begin
      errors++; $display("FAIL reset_seg got=%h exp=00", bus0.seg);
    end
  endtask

  task automatic test_rotation;
    logic [3:0] exp_an;
    logic [3:0] exp_an1;
    do_reset(16'h0000, 1'b0);
    for (int n = 1; n <= 17; n++) begin
      @(negedge clk);
      exp_an  = 4'(1 << (((n - 1) / 4) % 4));
      exp_an1 = 4'(1 << ((n - 1) % 4));
      checks++;
      if (bus0.an !== exp_an) begin
        errors++; $display("FAIL rot_an n=%0d got=%b exp=%b", n, bus0.an, exp_an);
      end
      checks++;
      if (bus0.seg !== 7'h3F) begin
        errors++; $display("FAIL rot_seg n=%0d got=%h exp=3f", n, bus0.seg);
      end
      checks++;
      if (bus1.an !== exp_an1) begin
        errors++; $display("FAIL div1_an n=%0d got=%b exp=%b", n, bus1.an, exp_an1);
      end
    end
  endtask

  task automatic test_load;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h6D, 7'h3F, 7'h66, 7'h06};
    bus0.blank_lead = 1'b0;
    do_reset(16'h1405, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus0.load = 1'b0;
      if (n >= 2) begin
        checks++;
        if (bus0.seg !== exp_seg[(n - 1) / 4]) begin
          errors++; $display("FAIL load1405 n=%0d got=%h exp=%h", n, bus0.seg, exp_seg[(n - 1) / 4]);
        end
      end
    end
  endtask

  task automatic test_blanking;
    logic [6:0] exp_a [4];
    logic [6:0] exp_b [4];
    logic [3:0] exp_an;
    exp_a = '{7'h6D, 7'h00, 7'h00, 7'h00};
    exp_b = '{7'h3F, 7'h00, 7'h00, 7'h00};
    bus0.blank_lead = 1'b1;
    do_reset(16'h0005, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus0.load = 1'b0;
      exp_an = 4'(1 << ((n - 1) / 4));
      if (n >= 2) begin
        checks++;
        if (bus0.seg !== exp_a[(n - 1) / 4] || bus0.an !== exp_an) begin
          errors++; $display("FAIL blank0005 n=%0d got=%h/%b exp=%h/%b", n, bus0.seg, bus0.an, exp_a[(n - 1) / 4], exp_an);
        end
      end
    end
    do_reset(16'h0000, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus0.load = 1'b0;
      exp_an = 4'(1 << ((n - 1) / 4));
      checks++;
      if (bus0.seg !== exp_b[(n - 1) / 4] || bus0.an !== exp_an) begin
        errors++; $display("FAIL blank0000 n=%0d got=%h/%b exp=%h/%b", n, bus0.seg, bus0.an, exp_b[(n - 1) / 4], exp_an);
      end
    end
  endtask

  task automatic test_dash;
    logic [6:0] exp_seg [4];
    exp_seg = '{7'h3F, 7'h40, 7'h00, 7'h00};
    bus0.blank_lead = 1'b1;
    do_reset(16'h00C0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      bus0.load = 1'b0;
      if (n >= 2) begin
        checks++;
        if (bus0.seg !== exp_seg[(n - 1) / 4]) begin
          errors++; $display("FAIL dash00C0 n=%0d got=%h exp=%h", n, bus0.seg, exp_seg[(n - 1) / 4]);
        end
      end
    end
    bus0.blank_lead = 1'b0;
  endtask

  task automatic test_load_advance_reset;
    bus0.blank_lead = 1'b0;
    do_reset(16'h0000, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 3) begin
        bus0.digits_bcd = 16'h0090;
        bus0.load = 1'b1;
      end
      if (n == 4) begin
        bus0.load = 1'b0;
        checks++;
        if (bus0.an !== 4'b0001 || bus0.seg !== 7'h3F) begin
          errors++; $display("FAIL adv_before got=%h/%b exp=3f/0001", bus0.seg, bus0.an);
        end
      end
      if (n == 5) begin
        checks++;
        if (bus0.an !== 4'b0010 || bus0.seg !== 7'h6F) begin
          errors++; $display("FAIL adv_after got=%h/%b exp=6f/0010", bus0.seg, bus0.an);
        end
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus0.an !== 4'b0000 || bus0.seg !== 7'h00) begin
      errors++; $display("FAIL async_reset got=%h/%b exp=00/0000", bus0.seg, bus0.an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) begin
        checks++;
        if (bus0.an !== 4'b0001 || bus0.seg !== 7'h3F) begin
          errors++; $display("FAIL restart_d0 got=%h/%b exp=3f/0001", bus0.seg, bus0.an);
        end
      end
      if (n == 5) begin
        checks++;
        if (bus0.an !== 4'b0010 || bus0.seg !== 7'h3F) begin
          errors++; $display("FAIL restart_d1 got=%h/%b exp=3f/0010", bus0.seg, bus0.an);
        end
      end
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink;
    do_reset(16'h0000, 1'b0);
    bus0.blink_en = 1'b1;
    for (int n = 1; n <= 66; n++) begin
      @(negedge clk);
      if (n == 32) begin
        checks++;
        if (bus0.an !== 4'b1000) begin
          errors++; $display("FAIL blink_on_end got=%b exp=1000", bus0.an);
        end
      end
      if (n == 33 || n == 40 || n == 50 || n == 64) begin
        checks++;
        if (bus0.an !== 4'b0000 || bus0.seg !== 7'h00) begin
          errors++; $display("FAIL blink_off n=%0d got=%h/%b exp=00/0000", n, bus0.seg, bus0.an);
        end
      end
      if (n == 40) bus0.blink_en = 1'b0;
      if (n == 41) begin
        checks++;
        if (bus0.an !== 4'b0100 || bus0.seg !== 7'h3F) begin
          errors++; $display("FAIL blink_resume got=%h/%b exp=3f/0100", bus0.seg, bus0.an);
        end
        bus0.blink_en = 1'b1;
      end
      if (n == 65) begin
        checks++;
        if (bus0.an !== 4'b0001) begin
          errors++; $display("FAIL blink_on_again got=%b exp=0001", bus0.an);
        end
      end
    end
    bus0.blink_en = 1'b0;
  endtask
`else
  task automatic test_blink;
    logic [3:0] exp_an;
    do_reset(16'h0000, 1'b0);
    bus0.blink_en = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n >= 33) begin
        exp_an = 4'(1 << (((n - 1) / 4) % 4));
        checks++;
        if (bus0.an !== exp_an || bus0.seg !== 7'h3F) begin
          errors++; $display("FAIL noblink n=%0d got=%h/%b exp=3f/%b", n, bus0.seg, bus0.an, exp_an);
        end
      end
    end
    bus0.blink_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_rotation();
    test_load();
    test_blanking();
    test_dash();
    test_load_advance_reset();
    test_blink();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
